// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the phase-offset clock generator:
// FSM state encoding, minimum divide ratio and configuration clamping.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

    typedef struct packed {
        logic [31:0] div;
        logic [31:0] phase;
    } cfg_pair_t;

    // A ratio below DIV_MIN cannot make a clock; a phase must fall inside one period.
    function automatic cfg_pair_t clamp_cfg(input logic [31:0] div, input logic [31:0] phase);
        cfg_pair_t r;
        r.div   = (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
        r.phase = (phase >= r.div) ? (r.div - 32'd1) : phase;
        return r;
    endfunction

endpackage

// File: rtl/clk_div_phase_if.sv
// Configuration port of the clock generator: divide ratio and phase offset.
// Handshake: a transfer happens on every mclk edge where cfg_valid && cfg_ready;
// the master holds cfg_div/cfg_phase stable while cfg_valid is high, and
// cfg_ready never depends on cfg_valid.
interface clk_div_phase_if #(parameter int DIV_W = 8) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;

    modport master (output cfg_valid, output cfg_div, output cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, input cfg_phase, output cfg_ready);

endinterface

// File: rtl/clk_cfg_shadow.sv
// Shadow register for a requested divide/phase pair. Holds one clamped pair
// until the generator applies it at a period boundary.
module clk_cfg_shadow
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic              mclk,
    input  logic              rst,
    clk_div_phase_if.slave    cfg,
    input  logic              apply,
    output logic              pending,
    output logic [DIV_W-1:0]  sh_div,
    output logic [DIV_W-1:0]  sh_phase
);

    cfg_pair_t clamped;
    logic      accept;
    logic      unused_hi;

    always_comb begin
        clamped = clamp_cfg(32'(cfg.cfg_div), 32'(cfg.cfg_phase));
    end

    assign unused_hi     = ^{clamped.div[31:DIV_W], clamped.phase[31:DIV_W]};
    assign cfg.cfg_ready = !pending;
    assign accept        = cfg.cfg_valid && !pending;

    always_ff @(posedge mclk) begin
        if (rst) begin
            pending  <= 1'b0;
            sh_div   <= '0;
            sh_phase <= '0;
        end else if (accept) begin
            pending  <= 1'b1;
            sh_div   <= clamped.div[DIV_W-1:0];
            sh_phase <= clamped.phase[DIV_W-1:0];
        end else if (apply) begin
            pending  <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_phase.sv
// Divided, phase-offset clock generator. Settings change only at a period
// boundary, so bclk never shows a runt pulse; all outputs are registered.
module clk_div_phase
    import clk_gen_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              en,
    clk_div_phase_if.slave    cfg,
    output logic              bclk,
    output logic              bclk_rise,
    output logic              locked,
    output logic [DIV_W-1:0]  act_div,
    output logic [DIV_W-1:0]  act_phase,
    output state_t            dbg_state
);

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] dly, dly_n;
    logic [DIV_W-1:0] act_div_n, act_phase_n;
    logic [DIV_W-1:0] sh_div, sh_phase, start_phase;
    logic [DIV_W:0]   phase_diff;
    logic             pending, apply, last;
    logic             unused_msb;

    clk_cfg_shadow #(.DIV_W(DIV_W)) u_shadow (
        .mclk     (mclk),
        .rst      (rst),
        .cfg      (cfg),
        .apply    (apply),
        .pending  (pending),
        .sh_div   (sh_div),
        .sh_phase (sh_phase)
    );

    // Extra delay needed to move from the old phase to the new one, mod the new ratio.
    always_comb begin
        if (sh_phase >= act_phase)
            phase_diff = {1'b0, sh_phase} - {1'b0, act_phase};
        else
            phase_diff = {1'b0, sh_phase} + {1'b0, sh_div} - {1'b0, act_phase};
    end

    assign unused_msb  = phase_diff[DIV_W];
    assign last        = (cnt == act_div - 1'b1);
    assign start_phase = pending ? sh_phase : act_phase;
    assign dbg_state   = state;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dly_n       = dly;
        act_div_n   = act_div;
        act_phase_n = act_phase;
        apply       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    apply       = 1'b1;
                    act_div_n   = sh_div;
                    act_phase_n = sh_phase;
                end
                if (en) begin
                    cnt_n = '0;
                    if (start_phase != '0) begin
                        dly_n   = start_phase;
                        state_n = DELAY;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            DELAY: begin
                dly_n = dly - 1'b1;
                if (dly <= 1) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (!last) begin
                    cnt_n = cnt + 1'b1;
                end else if (!en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (pending) begin
                    apply       = 1'b1;
                    act_div_n   = sh_div;
                    act_phase_n = sh_phase;
                    cnt_n       = '0;
                    if (sh_phase != act_phase && phase_diff[DIV_W-1:0] != '0) begin
                        dly_n   = phase_diff[DIV_W-1:0];
                        state_n = DELAY;
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dly       <= '0;
            act_div   <= DIV_W'(DEFAULT_DIV);
            act_phase <= '0;
            bclk      <= 1'b0;
            bclk_rise <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dly       <= dly_n;
            act_div   <= act_div_n;
            act_phase <= act_phase_n;
            // Odd ratios get the shorter half high because of the floor in >>1.
            bclk      <= (state_n == RUN) && (cnt_n < (act_div_n >> 1));
            bclk_rise <= (state_n == RUN) && (cnt_n == '0);
            locked    <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_clk_div_phase.sv
// Directed bench for clk_div_phase: expected {bclk, bclk_rise, locked} per
// mclk cycle is queued ahead of stimulus and popped as the DUT runs.
module tb_clk_div_phase;
  import clk_gen_pkg::*;

  localparam int DIV_W = 8;

  logic             mclk = 1'b0;
  logic             rst  = 1'b1;
  logic             en   = 1'b0;
  logic             bclk, bclk_rise, locked;
  logic [DIV_W-1:0] act_div, act_phase;
  state_t           dbg_state;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [2:0] exp_q[$];

  clk_div_phase_if #(.DIV_W(DIV_W)) cfg_if ();

  clk_div_phase #(.DIV_W(DIV_W), .DEFAULT_DIV(10)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg_if),
    .bclk      (bclk),
    .bclk_rise (bclk_rise),
    .locked    (locked),
    .act_div   (act_div),
    .act_phase (act_phase),
    .dbg_state (dbg_state)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Expected waveform builders: {bclk, bclk_rise, locked}
  task automatic push_const(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_period(input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int c = 0; c < n; c++)
        exp_q.push_back({(c < n / 2) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0, 1'b1});
  endtask

  task automatic tick(input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wave", {29'd0, bclk, bclk_rise, locked}, {29'd0, e});
      end
    end
  endtask

  task automatic cfg_send(input int div, input int phase);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = DIV_W'(div);
    cfg_if.cfg_phase = DIV_W'(phase);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = DIV_W'($urandom_range(0, 255));
    cfg_if.cfg_phase = DIV_W'($urandom_range(0, 255));
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;

    // reset values
    tick(2);
    chk("rst_bclk", {31'd0, bclk}, 32'd0);
    chk("rst_rise", {31'd0, bclk_rise}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("rst_div", {24'd0, act_div}, 32'd10);
    chk("rst_phase", {24'd0, act_phase}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;

    // start with no offset, N=10 P=0
    push_const(3'b000, 2);
    cfg_send(10, 0);
    chk("ready_low_after_capture", {31'd0, cfg_if.cfg_ready}, 32'd0);
    tick(1);
    chk("ready_after_idle_apply", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("div_n10", {24'd0, act_div}, 32'd10);
    en = 1'b1;
    push_period(10, 3);
    tick(30);

    // stop requested at cnt=2: the period completes, then IDLE
    push_period(10, 1);
    tick(3);
    en = 1'b0;
    push_const(3'b000, 3);
    tick(10);
    chk("stop_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // phase offset N=10 P=3: first rise three cycles late
    push_const(3'b000, 2);
    cfg_send(10, 3);
    tick(1);
    chk("phase_p3", {24'd0, act_phase}, 32'd3);
    en = 1'b1;
    push_const(3'b000, 3);
    push_period(10, 3);
    tick(33);

    // phase change 3 -> 1 mid-period: 8-cycle unlocked gap after the boundary
    push_period(10, 1);
    tick(3);
    cfg_send(10, 1);
    chk("ready_low_pending_phase", {31'd0, cfg_if.cfg_ready}, 32'd0);
    tick(6);
    push_const(3'b000, 8);
    push_period(10, 2);
    tick(28);
    chk("phase_p1", {24'd0, act_phase}, 32'd1);
    chk("ready_after_phase_apply", {31'd0, cfg_if.cfg_ready}, 32'd1);

    // ratio change to N=4 accepted at cnt=3; current period stays 5/5
    push_period(10, 1);
    tick(3);
    cfg_send(4, 1);
    chk("ready_low_pending_div", {31'd0, cfg_if.cfg_ready}, 32'd0);
    tick(5);
    chk("div_still_10", {24'd0, act_div}, 32'd10);
    tick(1);
    push_period(4, 4);
    tick(16);
    chk("div_n4", {24'd0, act_div}, 32'd4);

    // stop at the last cycle of a period, then odd ratio N=5
    en = 1'b0;
    push_const(3'b000, 3);
    tick(3);
    push_const(3'b000, 2);
    cfg_send(5, 0);
    tick(1);
    chk("div_n5", {24'd0, act_div}, 32'd5);
    chk("phase_n5", {24'd0, act_phase}, 32'd0);
    en = 1'b1;
    push_period(5, 2);
    tick(10);
    en = 1'b0;
    push_const(3'b000, 2);
    tick(2);

    // ratio below minimum clamps to 2
    push_const(3'b000, 2);
    cfg_send(1, 0);
    tick(1);
    chk("div_clamp_2", {24'd0, act_div}, 32'd2);
    en = 1'b1;
    push_period(2, 3);
    tick(6);
    en = 1'b0;
    push_const(3'b000, 2);
    tick(2);

    // phase beyond ratio clamps to N-1
    push_const(3'b000, 2);
    cfg_send(6, 9);
    tick(1);
    chk("div_n6", {24'd0, act_div}, 32'd6);
    chk("phase_clamp_5", {24'd0, act_phase}, 32'd5);

    // reset during DELAY with a pending config: everything back to reset values
    en = 1'b1;
    push_const(3'b000, 3);
    tick(2);
    chk("in_delay", {30'd0, dbg_state}, {30'd0, DELAY});
    cfg_send(8, 2);
    chk("ready_low_in_delay", {31'd0, cfg_if.cfg_ready}, 32'd0);
    rst = 1'b1;
    en  = 1'b0;
    push_const(3'b000, 1);
    tick(1);
    chk("rst2_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("rst2_div", {24'd0, act_div}, 32'd10);
    chk("rst2_phase", {24'd0, act_phase}, 32'd0);
    chk("rst2_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;
    push_const(3'b000, 3);
    tick(3);
    chk("pending_dropped_div", {24'd0, act_div}, 32'd10);
    chk("pending_dropped_phase", {24'd0, act_phase}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
